// File: rtl/flexcounter_multi.sv
// NUM_CH independent up/down counters sharing one programmable prescaler tick.
// Each channel runs IDLE -> RUN -> (DONE in one-shot mode) with a registered strobe and sticky done flag.
module flexcounter_multi #(
    parameter int NUM_CH     = 4,
    parameter int COUNTSIZE  = 1024,
    parameter int COUNTWIDTH = $clog2(COUNTSIZE),
    parameter int PRESCALE_W = 8
) (
    input  logic                           clk,
    input  logic                           RST,
    input  logic [PRESCALE_W-1:0]          prescale,
    input  logic [NUM_CH-1:0]              enableCounter,
    input  logic [NUM_CH-1:0]              clearCounter,
    input  logic [NUM_CH-1:0]              countDown,
    input  logic [NUM_CH-1:0]              oneShot,
    input  logic [NUM_CH*COUNTWIDTH-1:0]   maxCount,
    output logic [NUM_CH-1:0]              strobe,
    output logic [NUM_CH*COUNTWIDTH-1:0]   count,
    output logic [NUM_CH-1:0]              done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [PRESCALE_W-1:0] preCnt_q, preCnt_d;
    logic                  anyEnable;
    logic                  tick;

    // >= rather than == so that lowering prescale mid-count never overruns.
    always_comb begin
        anyEnable = |enableCounter;
        tick      = anyEnable && (preCnt_q >= prescale);
        preCnt_d  = (!anyEnable || tick) ? '0 : preCnt_q + PRESCALE_W'(1);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            preCnt_q <= '0;
        end else begin
            preCnt_q <= preCnt_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t                state_q;
        logic [COUNTWIDTH-1:0] cnt_q;
        logic                  strobe_q;
        logic                  done_q;
        logic [COUNTWIDTH-1:0] maxVal;
        logic [COUNTWIDTH-1:0] startVal;
        logic                  terminal;

        assign maxVal   = maxCount[i*COUNTWIDTH +: COUNTWIDTH];
        assign startVal = countDown[i] ? maxVal : '0;
        // Up mode uses >= so a maxCount lowered below the live count still wraps.
        assign terminal = countDown[i] ? (cnt_q == '0) : (cnt_q >= maxVal);

        always_ff @(posedge clk or posedge RST) begin
            if (RST) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                strobe_q <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                strobe_q <= 1'b0;
                if (clearCounter[i]) begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    cnt_q   <= startVal;
                end else begin
                    case (state_q)
                        IDLE: begin
                            if (enableCounter[i]) begin
                                state_q <= RUN;
                            end
                        end
                        RUN: begin
                            if (enableCounter[i] && tick) begin
                                if (terminal) begin
                                    strobe_q <= 1'b1;
                                    if (oneShot[i]) begin
                                        state_q <= DONE;
                                        done_q  <= 1'b1;
                                    end else begin
                                        cnt_q <= startVal;
                                    end
                                end else if (countDown[i]) begin
                                    cnt_q <= cnt_q - COUNTWIDTH'(1);
                                end else begin
                                    cnt_q <= cnt_q + COUNTWIDTH'(1);
                                end
                            end
                        end
                        DONE: begin
                            done_q <= 1'b1;
                        end
                        default: begin
                            state_q <= IDLE;
                        end
                    endcase
                end
            end
        end

        assign strobe[i]                          = strobe_q;
        assign done[i]                            = done_q;
        assign count[i*COUNTWIDTH +: COUNTWIDTH]  = cnt_q;
    end

endmodule

// File: tb/tb_flexcounter_multi.sv
// Bench for flexcounter_multi: directed scenarios plus randomized traffic, all checked
// every cycle against a behavioural per-channel model of the counter rules.
module tb_flexcounter_multi;

    localparam int NCH = 4;
    localparam int CW  = 10;
    localparam int PW  = 8;

    logic              clk;
    logic              RST;
    logic [PW-1:0]     prescale;
    logic [NCH-1:0]    en, clr, down, os;
    logic [NCH*CW-1:0] maxCount;
    logic [NCH-1:0]    strobe;
    logic [NCH*CW-1:0] count;
    logic [NCH-1:0]    done;

    int testCount = 0;
    int failCount = 0;

    int mPre;
    int mCnt[NCH];
    bit mIdle[NCH];
    bit mFin[NCH];
    bit mStb[NCH];

    int t1Cnt[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    bit t1Stb[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};

    flexcounter_multi #(
        .NUM_CH    (NCH),
        .COUNTSIZE (1024),
        .PRESCALE_W(PW)
    ) dut (
        .clk          (clk),
        .RST          (RST),
        .prescale     (prescale),
        .enableCounter(en),
        .clearCounter (clr),
        .countDown    (down),
        .oneShot      (os),
        .maxCount     (maxCount),
        .strobe       (strobe),
        .count        (count),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mPre = 0;
        for (int i = 0; i < NCH; i++) begin
            mCnt[i]  = 0;
            mIdle[i] = 1'b1;
            mFin[i]  = 1'b0;
            mStb[i]  = 1'b0;
        end
    endtask

    // One clock of the counter rules, applied to the inputs held across the edge.
    task automatic modelStep();
        bit anyEn;
        bit tick;
        int mx;
        int start;
        anyEn = (en != '0);
        tick  = anyEn && (mPre >= int'(prescale));
        if (!anyEn || tick) mPre = 0;
        else mPre = mPre + 1;
        for (int i = 0; i < NCH; i++) begin
            mStb[i] = 1'b0;
            mx      = int'(maxCount[i*CW +: CW]);
            start   = down[i] ? mx : 0;
            if (clr[i]) begin
                mIdle[i] = 1'b1;
                mFin[i]  = 1'b0;
                mCnt[i]  = start;
            end else if (mFin[i]) begin
                mFin[i] = 1'b1;
            end else if (mIdle[i]) begin
                if (en[i]) mIdle[i] = 1'b0;
            end else if (en[i] && tick) begin
                if (down[i] ? (mCnt[i] == 0) : (mCnt[i] >= mx)) begin
                    mStb[i] = 1'b1;
                    if (os[i]) mFin[i] = 1'b1;
                    else mCnt[i] = start;
                end else begin
                    mCnt[i] = down[i] ? mCnt[i] - 1 : mCnt[i] + 1;
                end
            end
        end
    endtask

    task automatic compareAll();
        logic [NCH*CW-1:0] expCount;
        logic [NCH-1:0]    expStb;
        logic [NCH-1:0]    expDone;
        for (int i = 0; i < NCH; i++) begin
            expCount[i*CW +: CW] = CW'(mCnt[i]);
            expStb[i]            = mStb[i];
            expDone[i]           = mFin[i];
        end
        checkOutput("count", 64'(count), 64'(expCount));
        checkOutput("strobe", 64'(strobe), 64'(expStb));
        checkOutput("done", 64'(done), 64'(expDone));
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            compareAll();
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] e, input logic [NCH-1:0] c,
                                 input logic [NCH-1:0] d, input logic [NCH-1:0] o,
                                 input logic [NCH*CW-1:0] m, input logic [PW-1:0] p,
                                 input int n);
        en       = e;
        clr      = c;
        down     = d;
        os       = o;
        maxCount = m;
        prescale = p;
        runCycles(n);
    endtask

    initial begin
        RST      = 1'b1;
        prescale = '0;
        en       = '0;
        clr      = '0;
        down     = '0;
        os       = '0;
        maxCount = '0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_strobe", 64'(strobe), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        RST = 1'b0;

        // ch0 continuous up, maxCount=3, prescale=0
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, {10'd0, 10'd0, 10'd0, 10'd3}, 8'd0, 0);
        for (int k = 0; k < 9; k++) begin
            runCycles(1);
            checkOutput("t1_count", 64'(count[CW-1:0]), 64'(t1Cnt[k]));
            checkOutput("t1_strobe", 64'(strobe[0]), 64'(t1Stb[k]));
        end

        // ch1 one-shot down from 5, prescale=2
        applyStimulus(4'b0000, 4'b0010, 4'b0010, 4'b0010, {10'd0, 10'd0, 10'd5, 10'd3}, 8'd2, 1);
        checkOutput("t2_load", 64'(count[2*CW-1:CW]), 64'd5);
        applyStimulus(4'b0010, 4'b0000, 4'b0010, 4'b0010, {10'd0, 10'd0, 10'd5, 10'd3}, 8'd2, 40);
        checkOutput("t2_done", 64'(done[1]), 64'd1);
        checkOutput("t2_count", 64'(count[2*CW-1:CW]), 64'd0);
        runCycles(20);

        // ch2 up to 10, lowered to 4 once count reaches 7
        applyStimulus(4'b0000, 4'b0100, 4'b0000, 4'b0000, {10'd0, 10'd10, 10'd5, 10'd3}, 8'd0, 1);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, {10'd0, 10'd10, 10'd5, 10'd3}, 8'd0, 8);
        checkOutput("t3_count7", 64'(count[3*CW-1:2*CW]), 64'd7);
        applyStimulus(4'b0100, 4'b0000, 4'b0000, 4'b0000, {10'd0, 10'd4, 10'd5, 10'd3}, 8'd0, 1);
        checkOutput("t3_wrap", 64'(count[3*CW-1:2*CW]), 64'd0);
        checkOutput("t3_strobe", 64'(strobe[2]), 64'd1);

        // ch0 pause and resume, then clear with enable
        applyStimulus(4'b0000, 4'b0001, 4'b0000, 4'b0000, {10'd0, 10'd4, 10'd5, 10'd7}, 8'd0, 1);
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, {10'd0, 10'd4, 10'd5, 10'd7}, 8'd0, 3);
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, {10'd0, 10'd4, 10'd5, 10'd7}, 8'd0, 10);
        checkOutput("t4_hold", 64'(count[CW-1:0]), 64'd2);
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 4'b0000, {10'd0, 10'd4, 10'd5, 10'd7}, 8'd0, 1);
        checkOutput("t4_resume", 64'(count[CW-1:0]), 64'd3);
        applyStimulus(4'b0001, 4'b0001, 4'b0000, 4'b0000, {10'd0, 10'd4, 10'd5, 10'd7}, 8'd0, 1);
        checkOutput("t4_clear", 64'(count[CW-1:0]), 64'd0);

        for (int s = 0; s < 300; s++) begin
            logic [NCH-1:0]    e, c, d, o;
            logic [NCH*CW-1:0] m;
            logic [PW-1:0]     p;
            m = maxCount;
            d = down;
            o = os;
            for (int i = 0; i < NCH; i++) begin
                e[i] = ($urandom_range(0, 3) != 0);
                c[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) d[i] = ~d[i];
                if ($urandom_range(0, 7) == 0) o[i] = ~o[i];
                if ($urandom_range(0, 3) == 0) m[i*CW +: CW] = CW'($urandom_range(0, 7));
            end
            p = PW'($urandom_range(0, 3));
            applyStimulus(e, c, d, o, m, p, $urandom_range(1, 10));
        end

        // All channels terminal every tick, then asynchronous reset mid-run
        applyStimulus(4'b0000, 4'b1111, 4'b0000, 4'b0000, '0, 8'd0, 1);
        applyStimulus(4'b1111, 4'b0000, 4'b0000, 4'b0000, '0, 8'd0, 1);
        for (int k = 0; k < 4; k++) begin
            runCycles(1);
            checkOutput("t5_strobe", 64'(strobe), 64'hF);
            checkOutput("t5_count", 64'(count), 64'd0);
        end
        @(posedge clk);
        modelStep();
        #2 RST = 1'b1;
        #1;
        checkOutput("t5_rst_count", 64'(count), 64'd0);
        checkOutput("t5_rst_strobe", 64'(strobe), 64'd0);
        checkOutput("t5_rst_done", 64'(done), 64'd0);
        modelReset();
        @(negedge clk);
        RST = 1'b0;
        applyStimulus(4'b0011, 4'b0000, 4'b0001, 4'b0000, {10'd0, 10'd0, 10'd2, 10'd3}, 8'd1, 12);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
